// File: rtl/if_id_queue_pkg.sv
// Shared constants for the IF/ID instruction queue: pipeline control polarities,
// the zero word and the legal queue depth range.
package if_id_queue_pkg;

  localparam logic        STOP      = 1'b1;
  localparam logic        NO_STOP   = 1'b0;
  localparam logic        FLUSH_ON  = 1'b1;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  // Index of the ID stage within the 6-bit pipeline stall vector.
  localparam int STALL_ID_BIT = 1;

  localparam int DEPTH_MIN = 2;
  localparam int DEPTH_MAX = 8;

  function automatic bit depth_legal(input int d);
    return (d >= DEPTH_MIN) && (d <= DEPTH_MAX) && ((d & (d - 1)) == 0);
  endfunction

endpackage

// File: rtl/if_id_fifo_mem.sv
// Circular entry storage for the IF/ID queue with read/write pointers and a count.
// Callers guarantee push is never requested while full unless a pop happens too.
module if_id_fifo_mem
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 96,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [W-1:0]     i_wdata,
  output logic [W-1:0]     o_rdata,
  output logic [CNT_W-1:0] o_count
);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Storage carries no reset; only the pointers and count define what is live.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (i_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: a small FIFO behind the ID output register, with
// empty-queue bypass, flush, delay-slot tagging and a sticky overflow flag.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int EXC_W  = 32,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int ENT_W = ADDR_W + INST_W + EXC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [5:0]        stall,
  input  logic              if_valid,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic [INST_W-1:0] if_inst,
  input  logic [EXC_W-1:0]  if_excepttype,
  output logic              if_ready,
  input  logic              id_next_in_delay_slot,
  output logic              id_valid,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic [EXC_W-1:0]  id_excepttype,
  output logic              id_in_delay_slot,
  output logic [CNT_W-1:0]  occupancy,
  output logic              overflow
);

  logic              w_advance;
  logic              w_flush;
  logic              w_fifo_empty;
  logic              w_if_ready;
  logic              w_pop;
  logic              w_accept;
  logic              w_bypass;
  logic              w_enq;
  logic              w_deliver;
  logic              w_ovf_evt;
  logic [CNT_W-1:0]  w_count;
  logic [ENT_W-1:0]  w_head;
  logic [ENT_W-1:0]  w_in_entry;
  logic [ENT_W-1:0]  w_next_entry;
  logic              w_unused_stall;

  logic              r_valid;
  logic [ADDR_W-1:0] r_pc;
  logic [INST_W-1:0] r_inst;
  logic [EXC_W-1:0]  r_exc;
  logic              r_in_ds;
  logic              r_pending_ds;
  logic              r_overflow;

  assign w_unused_stall = ^{stall[5:STALL_ID_BIT+1], stall[STALL_ID_BIT-1:0]};

  assign w_advance    = (stall[STALL_ID_BIT] == NO_STOP);
  assign w_flush      = (flush == FLUSH_ON);
  assign w_fifo_empty = (w_count == '0);
  assign w_if_ready   = (w_count < CNT_W'(DEPTH));
  assign w_pop        = w_advance && !w_fifo_empty && !w_flush;
  // if_ready reports the pre-pop count; a full queue still takes an entry in a pop cycle.
  assign w_accept     = if_valid && !w_flush && (w_if_ready || w_pop);
  assign w_bypass     = w_accept && w_advance && w_fifo_empty;
  assign w_enq        = w_accept && !w_bypass;
  assign w_deliver    = w_advance && (!w_fifo_empty || w_accept);
  assign w_ovf_evt    = if_valid && !w_flush && !w_accept;

  assign w_in_entry   = {if_pc, if_inst, if_excepttype};
  assign w_next_entry = w_fifo_empty ? w_in_entry : w_head;

  if_id_fifo_mem #(
    .DEPTH (DEPTH),
    .W     (ENT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (w_flush),
    .i_push  (w_enq),
    .i_pop   (w_pop),
    .i_wdata (w_in_entry),
    .o_rdata (w_head),
    .o_count (w_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid      <= 1'b0;
      r_pc         <= ADDR_W'(ZERO_WORD);
      r_inst       <= INST_W'(ZERO_WORD);
      r_exc        <= EXC_W'(ZERO_WORD);
      r_in_ds      <= 1'b0;
      r_pending_ds <= 1'b0;
    end else if (w_flush) begin
      r_valid      <= 1'b0;
      r_pc         <= ADDR_W'(ZERO_WORD);
      r_inst       <= INST_W'(ZERO_WORD);
      r_exc        <= EXC_W'(ZERO_WORD);
      r_in_ds      <= 1'b0;
      r_pending_ds <= 1'b0;
    end else if (w_advance && w_deliver) begin
      r_valid                <= 1'b1;
      {r_pc, r_inst, r_exc}  <= w_next_entry;
      r_in_ds                <= r_pending_ds | id_next_in_delay_slot;
      r_pending_ds           <= 1'b0;
    end else if (w_advance) begin
      // Bubble: the pending delay-slot mark waits for the next real instruction.
      r_valid      <= 1'b0;
      r_pc         <= ADDR_W'(ZERO_WORD);
      r_inst       <= INST_W'(ZERO_WORD);
      r_exc        <= EXC_W'(ZERO_WORD);
      r_in_ds      <= 1'b0;
      r_pending_ds <= r_pending_ds | id_next_in_delay_slot;
    end else begin
      r_pending_ds <= r_pending_ds | id_next_in_delay_slot;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_overflow <= 1'b0;
    else if (w_ovf_evt) r_overflow <= 1'b1;
  end

  assign if_ready         = w_if_ready;
  assign id_valid         = r_valid;
  assign id_pc            = r_pc;
  assign id_inst          = r_inst;
  assign id_excepttype    = r_exc;
  assign id_in_delay_slot = r_in_ds;
  assign occupancy        = w_count;
  assign overflow         = r_overflow;

endmodule
